// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle between a byte source and uart_tx.
interface uart_tx_if;
  logic       start;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       done;

  // Byte source side.
  modport master (
    output start,
    output data,
    input  tx,
    input  busy,
    input  done
  );

  // Transmitter side.
  modport slave (
    input  start,
    input  data,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits (MSB-first by default), stop bit,
// then a one-cycle done pulse. All outputs are registered.
module uart_tx #(
  parameter int unsigned CYCLES    = 10416,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave tx_if
);

  localparam int unsigned    CntW    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StData    = 3'd2,
    StStop    = 3'd3,
    StCleanup = 3'd4
  } state_e;

  state_e          r_state, w_state;
  logic [CntW-1:0] r_cnt, w_cnt;
  logic [2:0]      r_bit, w_bit;
  logic [7:0]      r_shift, w_shift;
  logic            r_tx, w_tx;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            w_cnt_last;

  // Bit currently at the transmit end of the shift register.
  function automatic logic head_bit(input logic [7:0] s);
    return MSB_FIRST ? s[7] : s[0];
  endfunction

  // Shift register after the head bit has been sent.
  function automatic logic [7:0] advance(input logic [7:0] s);
    return MSB_FIRST ? {s[6:0], 1'b0} : {1'b0, s[7:1]};
  endfunction

  assign w_cnt_last = (r_cnt == LastCnt);

  // State and registered outputs; reset forces the line high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_tx    = r_tx;
    w_busy  = r_busy;
    w_done  = 1'b0;

    case (r_state)
      StIdle: begin
        w_tx   = 1'b1;
        w_busy = 1'b0;
        if (tx_if.start) begin
          w_state = StStart;
          w_shift = tx_if.data;
          w_cnt   = '0;
          w_bit   = '0;
          w_tx    = 1'b0;
          w_busy  = 1'b1;
        end
      end

      StStart: begin
        if (w_cnt_last) begin
          w_state = StData;
          w_cnt   = '0;
          w_tx    = head_bit(r_shift);
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      StData: begin
        if (w_cnt_last) begin
          w_cnt = '0;
          if (r_bit == 3'd7) begin
            w_state = StStop;
            w_tx    = 1'b1;
          end else begin
            w_bit   = r_bit + 1'b1;
            w_shift = advance(r_shift);
            w_tx    = head_bit(w_shift);
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      StStop: begin
        if (w_cnt_last) begin
          w_state = StCleanup;
          w_cnt   = '0;
          w_done  = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      StCleanup: begin
        w_state = StIdle;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end

      default: begin
        w_state = StIdle;
        w_cnt   = '0;
        w_bit   = '0;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign tx_if.tx   = r_tx;
  assign tx_if.busy = r_busy;
  assign tx_if.done = r_done;

endmodule
